uart_deserialize: RTL and testbench

UART_DESERIALIZE -- requirements
Module: uart_deserialize

---
 rtl/uart_deserialize.sv | 177 +++++++++++++++++
 tb/tb_uart_deserialize.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_deserialize.sv
// UART receiver: oversampled start-bit detection, 3-sample majority voting
// per bit, even/odd parity and stop-bit checking, and a single-entry output
// holding register with read handshake and sticky overrun flag.
module uart_deserialize #(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sample_tick,
    input  logic        rx,
    input  logic        read_ack,
    output logic [10:0] packet,
    output logic [7:0]  data,
    output logic        data_valid,
    output logic        parity_error,
    output logic        framing_error,
    output logic        overrun,
    output logic        busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SAMP_A   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SAMP_B   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] SAMP_C   = CW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic            stop_q;
    logic [1:0]      samp_q;
    logic            rx_meta_q;
    logic            rx_s_q;
    logic            rx_prev_q;
    logic            done_q;

    logic [10:0]     packet_q;
    logic            data_valid_q;
    logic            parity_error_q;
    logic            framing_error_q;
    logic            overrun_q;

    logic            maj_d;
    logic            wrap_d;
    logic            decide_d;

    // Majority of the two stored mid-bit samples and the current one.
    assign maj_d    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign wrap_d   = (cnt_q == CNT_LAST);
    assign decide_d = (cnt_q == SAMP_C);

    // Two-flop synchronizer; flops idle high like the line itself.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receive FSM: advances only on sample ticks, decides each bit mid-bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            samp_q    <= 2'b00;
            rx_prev_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (sample_tick) begin
                rx_prev_q <= rx_s_q;
                if (state_q == IDLE) begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_s_q) begin
                        state_q <= START;
                    end
                end else begin
                    cnt_q <= wrap_d ? '0 : cnt_q + 1'b1;
                    if (cnt_q == SAMP_A) begin
                        samp_q[0] <= rx_s_q;
                    end
                    if (cnt_q == SAMP_B) begin
                        samp_q[1] <= rx_s_q;
                    end
                    case (state_q)
                        START: begin
                            if (decide_d && maj_d) begin
                                state_q <= IDLE;
                            end else if (wrap_d) begin
                                state_q   <= DATA;
                                bit_idx_q <= 3'd0;
                            end
                        end
                        DATA: begin
                            if (decide_d) begin
                                shift_q[bit_idx_q] <= maj_d;
                            end
                            if (wrap_d) begin
                                if (bit_idx_q == 3'd7) begin
                                    state_q <= PARITY;
                                end else begin
                                    bit_idx_q <= bit_idx_q + 3'd1;
                                end
                            end
                        end
                        PARITY: begin
                            if (decide_d) begin
                                par_q <= maj_d;
                            end
                            if (wrap_d) begin
                                state_q <= STOP;
                            end
                        end
                        STOP: begin
                            if (decide_d) begin
                                stop_q  <= maj_d;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    // Output holding register: deliver, drop on overrun, or release on ack.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            packet_q        <= 11'd0;
            data_valid_q    <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else if (done_q) begin
            if (!data_valid_q || read_ack) begin
                packet_q        <= {stop_q, par_q, shift_q, 1'b0};
                parity_error_q  <= (^shift_q) ^ par_q ^ PARITY_ODD;
                framing_error_q <= !stop_q;
                data_valid_q    <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (read_ack) begin
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end
    end

    assign packet        = packet_q;
    assign data          = packet_q[8:1];
    assign data_valid    = data_valid_q;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_deserialize.sv
// Directed and randomized bench for uart_deserialize, checked against a
// frame-level model of the holding register, error flags and overrun.
module tb_uart_deserialize;

    localparam int OS       = 16;
    localparam bit ODD      = 1'b0;
    localparam int TICK_DIV = 3;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        rx = 1'b1;
    logic        read_ack = 1'b0;
    logic [10:0] packet;
    logic [7:0]  data;
    logic        data_valid;
    logic        parity_error;
    logic        framing_error;
    logic        overrun;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int tickDiv = 0;

    logic        mValid;
    logic [10:0] mPacket;
    logic        mPe;
    logic        mFe;
    logic        mOverrun;

    uart_deserialize #(
        .OVERSAMPLE (OS),
        .PARITY_ODD (ODD)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .sample_tick   (sample_tick),
        .rx            (rx),
        .read_ack      (read_ack),
        .packet        (packet),
        .data          (data),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun       (overrun),
        .busy          (busy)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // One-clock sample tick every TICK_DIV clocks.
    always @(negedge clock) begin
        tickDiv = (tickDiv == TICK_DIV - 1) ? 0 : tickDiv + 1;
        sample_tick = (tickDiv == 0);
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [10:0] makePacket(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    function automatic logic rightParity(input logic [7:0] d);
        return (^d) ^ ODD;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mValid   = 1'b0;
        mPacket  = 11'd0;
        mPe      = 1'b0;
        mFe      = 1'b0;
        mOverrun = 1'b0;
    endtask

    task automatic modelComplete(input logic [10:0] pkt, input bit ackSame);
        if (!mValid || ackSame) begin
            mPacket = pkt;
            mPe     = (^pkt[8:1]) ^ pkt[9] ^ ODD;
            mFe     = !pkt[10];
            mValid  = 1'b1;
        end else begin
            mOverrun = 1'b1;
        end
    endtask

    task automatic modelAck();
        mValid   = 1'b0;
        mOverrun = 1'b0;
    endtask

    task automatic checkModel(input string tag);
        logic [7:0] expData;
        expData = mPacket[8:1];
        checkOutput({tag, ".valid"},   32'(data_valid),    32'(mValid));
        checkOutput({tag, ".packet"},  32'(packet),        32'(mPacket));
        checkOutput({tag, ".data"},    32'(data),          32'(expData));
        checkOutput({tag, ".parErr"},  32'(parity_error),  32'(mPe));
        checkOutput({tag, ".frmErr"},  32'(framing_error), 32'(mFe));
        checkOutput({tag, ".overrun"}, 32'(overrun),       32'(mOverrun));
    endtask

    task automatic sendBit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clock);
    endtask

    task automatic idleBits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clock);
    endtask

    task automatic pulseAck();
        read_ack = 1'b1;
        @(negedge clock);
        read_ack = 1'b0;
        modelAck();
    endtask

    // Sends one frame; optionally raises read_ack on the delivery clock,
    // which is the clock right after busy drops in the stop bit.
    task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stop, input bit ackAtDone);
        logic [10:0] bits;
        bit acked;
        bits  = makePacket(d, par, stop);
        acked = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sendBit(bits[i]);
        end
        rx = stop;
        for (int c = 0; c < BIT_CLKS; c++) begin
            @(negedge clock);
            if (read_ack) begin
                read_ack = 1'b0;
            end else if (ackAtDone && !acked && busy === 1'b0) begin
                read_ack = 1'b1;
                acked    = 1'b1;
            end
        end
        if (read_ack) begin
            @(negedge clock);
            read_ack = 1'b0;
        end
        if (ackAtDone) begin
            checkOutput("ackWindow", 32'(acked), 32'd1);
        end
        modelComplete(bits, ackAtDone);
    endtask

    initial begin
        logic [7:0] d;
        logic       par;
        logic       stop;
        int         mode;

        modelReset();
        repeat (3) @(negedge clock);
        checkModel("reset");
        checkOutput("reset.busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        idleBits(2);

        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0);
        idleBits(1);
        checkModel("a5");
        checkOutput("a5.literal", 32'(packet), 32'(11'b1_0_10100101_0));
        checkOutput("a5.busy", 32'(busy), 32'd0);
        pulseAck();
        checkModel("a5.ack");
        pulseAck();
        checkModel("a5.ackIdle");

        rx = 1'b0;
        repeat (12) @(negedge clock);
        checkOutput("glitch.busyHigh", 32'(busy), 32'd1);
        repeat (7) @(negedge clock);
        idleBits(2);
        checkOutput("glitch.busyLow", 32'(busy), 32'd0);
        checkModel("glitch");

        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b0);
        idleBits(1);
        checkModel("par3c");
        checkOutput("par3c.flag", 32'(parity_error), 32'd1);
        pulseAck();

        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3 * BIT_CLKS) @(negedge clock);
        checkModel("frame00");
        checkOutput("frame00.flag", 32'(framing_error), 32'd1);
        checkOutput("frame00.busy", 32'(busy), 32'd0);
        pulseAck();
        idleBits(12);
        checkModel("frame00.noRetrig");
        checkOutput("frame00.idleBusy", 32'(busy), 32'd0);

        applyStimulus(8'h11, 1'b0, 1'b1, 1'b0);
        idleBits(1);
        applyStimulus(8'h22, 1'b0, 1'b1, 1'b0);
        idleBits(1);
        checkModel("overrun");
        checkOutput("overrun.flag", 32'(overrun), 32'd1);
        pulseAck();
        checkModel("overrun.ack");

        applyStimulus(8'h44, 1'b0, 1'b1, 1'b0);
        idleBits(1);
        applyStimulus(8'h55, 1'b0, 1'b1, 1'b1);
        idleBits(1);
        checkModel("coincide");
        checkOutput("coincide.data", 32'(data), 32'h55);
        pulseAck();

        applyStimulus(8'h99, 1'b0, 1'b1, 1'b0);
        idleBits(1);
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        reset_n = 1'b0;
        rx      = 1'b1;
        modelReset();
        repeat (3) @(negedge clock);
        checkModel("midReset");
        checkOutput("midReset.busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        idleBits(2);
        checkModel("midReset.after");
        applyStimulus(8'hC3, rightParity(8'hC3), 1'b1, 1'b0);
        idleBits(1);
        checkModel("postReset");
        pulseAck();

        for (int n = 0; n < 12; n++) begin
            d    = 8'($urandom_range(0, 255));
            par  = rightParity(d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            mode = $urandom_range(0, 2);
            applyStimulus(d, par, stop, mode == 2);
            idleBits(1);
            checkModel("rand");
            checkOutput("rand.busy", 32'(busy), 32'd0);
            if (mode == 0) begin
                pulseAck();
                checkModel("rand.ack");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
